// File: rtl/bcd_xs3_seq_ctrl.sv
// bcd_xs3_seq_ctrl: multi-digit BCD to Excess-3 via one shared digit converter, LSD first; BCD_XS3_ERR_CHECK_EN adds a range check
module bcd_xs3_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic [4*DIGITS-1:0] src;
  logic [IDX_W-1:0] idx;
  logic [3:0] dig, xs3;
  logic last, accept;
  assign dig = src[4*idx +: 4];
  assign last = idx == IDX_W'(DIGITS - 1);
  assign accept = state == IDLE && in_valid;
`ifdef BCD_XS3_ERR_CHECK_EN
  logic bad;
  assign bad = dig > 4'd9;
  assign xs3 = bad ? 4'd0 : dig + 4'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (state == CONV) err <= err | bad;
`else
  assign xs3 = dig + 4'd3;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (in_valid ? CONV : IDLE) :
               state == CONV ? (last ? DONE : CONV) :
               (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    busy = state != IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src <= '0;
      idx <= '0;
      out_xs3 <= '0;
    end else if (accept) begin
      src <= in_bcd;
      idx <= '0;
      out_xs3 <= '0;
    end else if (state == CONV) begin
      out_xs3[4*idx +: 4] <= xs3;
      idx <= last ? '0 : idx + 1'b1;
    end
endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// tb_bcd_xs3_seq_ctrl: scoreboard bench for bcd_xs3_seq_ctrl (DIGITS=4 and DIGITS=1 instances)
module tb_bcd_xs3_seq_ctrl;
`ifdef BCD_XS3_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy, err;
  logic [15:0] in_bcd = '0, out_xs3;
  logic in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic in_ready1, out_valid1, busy1, err1;
  logic [3:0] in_bcd1 = '0, out_xs3_1;
  int checks = 0, errors = 0, nout = 0, nexp = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_xs3_seq_ctrl #(.DIGITS(4), .IDX_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_xs3(out_xs3), .busy(busy), .err(err)
  );
  bcd_xs3_seq_ctrl #(.DIGITS(1), .IDX_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_bcd(in_bcd1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_xs3(out_xs3_1), .busy(busy1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] w);
    logic [15:0] r;
    logic e;
    logic [3:0] d;
    r = '0;
    e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = w[4*k +: 4];
      if (d > 4'd9 && ERR_EN) begin
        e = 1'b1;
        r[4*k +: 4] = 4'd0;
      end else r[4*k +: 4] = d + 4'd3;
    end
    return {e, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int i;
    in_bcd = w;
    in_valid = 1'b1;
    for (i = 0; i < 40 && !in_ready; i++) tick();
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(model(w));
    nexp++;
    tick();
    in_valid = 1'b0;
    in_bcd = 16'hFFFF;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);
    tick();
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      nout++;
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("xs3", {16'd0, out_xs3}, {16'd0, e[15:0]});
        check("err", {31'd0, err}, {31'd0, e[16]});
      end
    end

  initial begin
    int acc[2];
    int n, cyc, i;
    logic [15:0] words[2];
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_xs3", {16'd0, out_xs3}, 0);
    check("rst_err", {31'd0, err}, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 1);
    // basic word, latency and in_ready recovery
    out_ready = 1'b1;
    send(16'h1234);
    check("t1_in_ready_low", {31'd0, in_ready}, 0);
    check("t1_busy", {31'd0, busy}, 1);
    tick(); tick(); tick();
    check("t1_not_yet_valid", {31'd0, out_valid}, 0);
    tick();
    check("t1_valid", {31'd0, out_valid}, 1);
    tick();
    check("t1_idle_valid", {31'd0, out_valid}, 0);
    check("t1_idle_ready", {31'd0, in_ready}, 1);
    // backpressure
    out_ready = 1'b0;
    send(16'h0999);
    for (i = 0; i < 20 && !out_valid; i++) tick();
    for (int k = 0; k < 10; k++) begin
      check("t2_hold_valid", {31'd0, out_valid}, 1);
      check("t2_hold_xs3", {16'd0, out_xs3}, 32'h3CCC);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t2_released", {31'd0, out_valid}, 0);
    check("t2_in_ready", {31'd0, in_ready}, 1);
    // back-to-back with in_valid held high
    words[0] = 16'h0000;
    words[1] = 16'h9876;
    n = 0;
    in_bcd = words[0];
    in_valid = 1'b1;
    for (cyc = 0; cyc < 30 && n < 2; cyc++) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(words[n]));
        nexp++;
        acc[n] = cyc;
        n++;
      end
      tick();
      if (n == 2) in_valid = 1'b0;
      else in_bcd = words[n];
    end
    check("t3_accepts", n, 2);
    check("t3_spacing", acc[1] - acc[0], 6);
    drain();
    // async reset mid-conversion
    send(16'h4321);
    tick(); tick();
    check("t4_partial", {16'd0, out_xs3}, 32'h0054);
    #2 rst_n = 1'b0;
    exp_q.delete();
    nexp--;
    #1;
    check("t4_rst_valid", {31'd0, out_valid}, 0);
    check("t4_rst_busy", {31'd0, busy}, 0);
    check("t4_rst_xs3", {16'd0, out_xs3}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("t4_in_ready", {31'd0, in_ready}, 1);
    send(16'h5555);
    drain();
    if (ERR_EN) begin
      send(16'h12A4);
      drain();
      send(16'h0001);
      drain();
    end
    // single-digit instance
    in_bcd1 = 4'h7;
    in_valid1 = 1'b1;
    check("d1_in_ready", {31'd0, in_ready1}, 1);
    tick();
    in_valid1 = 1'b0;
    check("d1_not_yet", {31'd0, out_valid1}, 0);
    tick();
    check("d1_valid", {31'd0, out_valid1}, 1);
    check("d1_xs3", {28'd0, out_xs3_1}, 32'hA);
    out_ready1 = 1'b1;
    tick();
    check("d1_done", {31'd0, out_valid1}, 0);
    check("sb_empty", exp_q.size(), 0);
    check("n_out", nout, nexp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
